cpc_bus_initiator: RTL

Z80-side bus-cycle generator for the CPC expansion bench and host-emulation boards. It turns single-beat commands into cycle-accurate Z80 bus transactions: memory read, opcode fetch with refresh, memory write, I/O read and I/O write. It drives the same strobes the RAM expansion CPLD decodes: `mreq_b`, `iorq_b`, `rd_b`, `wr_b`, `m1_b`, `rfsh_b`, address and data. It honours `ready` wait states and has a wait timeout. One `clk` period models one Z80 T-state.

---
 rtl/cpc_bus_initiator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cpc_bus_initiator.sv
// Z80-side bus-cycle generator: turns single-beat commands into T-state accurate
// memory, opcode-fetch (with refresh) and I/O bus transactions with wait/timeout.
module cpc_bus_initiator #(
  parameter logic [7:0] MAX_WAIT = 8'd255,
  parameter logic [7:0] IREG     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic        cmd_m1,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        m1_b,
  output logic        rfsh_b,
  input  logic        ready
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4} state_t;
  typedef enum logic [1:0] {C_MRD = 2'b00, C_MWR = 2'b01, C_IOWR = 2'b10, C_IORD = 2'b11} cmd_t;

  state_t      r_state, w_state_nxt;
  cmd_t        r_type, w_type;
  logic        r_m1, w_m1;
  logic [15:0] r_addr, w_addr;
  logic [7:0]  r_wdata, w_wdata;
  logic [7:0]  r_wcnt;
  logic        r_err;
  logic [7:0]  r_r;

  logic w_accept, w_sample, w_ready_ok, w_go;
  logic w_done, w_fetch_cap, w_tmo_hit;
  logic w_refresh, w_active, w_strobe, w_is_wr;
  logic [15:0] w_adr;
  logic [7:0]  w_dout;
  logic w_oe, w_mreq_b, w_iorq_b, w_rd_b, w_wr_b, w_m1_b, w_rfsh_b;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;

  // Command fields are used straight from the ports on the accept edge so T1
  // outputs can be registered on that same edge.
  assign w_type  = w_accept ? cmd_t'(cmd_type) : r_type;
  assign w_m1    = w_accept ? (cmd_m1 & (cmd_type == 2'b00)) : r_m1;
  assign w_addr  = w_accept ? cmd_addr : r_addr;
  assign w_wdata = w_accept ? cmd_wdata : r_wdata;

  assign w_sample   = ((r_state == S_T2) && !r_type[1]) || (r_state == S_TWA) || (r_state == S_TW);
  assign w_ready_ok = (MAX_WAIT == 8'd0) || ready;
  assign w_go       = w_ready_ok || (r_wcnt == MAX_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_fetch_cap = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_T1;
      S_T1:   w_state_nxt = S_T2;
      S_T2: begin
        if (r_type[1])  w_state_nxt = S_TWA;
        else if (w_go)  w_state_nxt = S_T3;
        else            w_state_nxt = S_TW;
      end
      S_TWA, S_TW: w_state_nxt = w_go ? S_T3 : S_TW;
      S_T3: begin
        if (r_m1) begin
          w_state_nxt = S_T4;
        end else begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      S_T4: begin
        w_state_nxt = S_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_sample && (w_state_nxt == S_T3)) begin
      w_tmo_hit   = !w_ready_ok;
      w_fetch_cap = r_m1;
    end
  end

  // Bus outputs are decoded from the state being entered, then registered.
  always_comb begin
    w_adr     = adr;
    w_dout    = data_out;
    w_oe      = 1'b0;
    w_mreq_b  = 1'b1;
    w_iorq_b  = 1'b1;
    w_rd_b    = 1'b1;
    w_wr_b    = 1'b1;
    w_m1_b    = 1'b1;
    w_rfsh_b  = 1'b1;
    w_refresh = r_m1 && ((w_state_nxt == S_T3) || (w_state_nxt == S_T4));
    w_active  = (w_state_nxt == S_T1) || (w_state_nxt == S_T2) || (w_state_nxt == S_TWA) ||
                (w_state_nxt == S_TW) || (w_state_nxt == S_T3);
    w_strobe  = (w_state_nxt != S_T1);
    w_is_wr   = (w_type == C_MWR) || (w_type == C_IOWR);
    if (w_refresh) begin
      w_mreq_b = 1'b0;
      w_rfsh_b = 1'b0;
      w_adr    = {IREG, r_r};
    end else if (w_active) begin
      w_adr = w_addr;
      w_oe  = w_is_wr;
      if (w_is_wr) w_dout = w_wdata;
      case (w_type)
        C_MRD: begin
          w_mreq_b = 1'b0;
          w_rd_b   = 1'b0;
          w_m1_b   = ~w_m1;
        end
        C_MWR: begin
          w_mreq_b = 1'b0;
          w_wr_b   = ~w_strobe;
        end
        C_IOWR: begin
          w_iorq_b = ~w_strobe;
          w_wr_b   = ~w_strobe;
        end
        default: begin
          w_iorq_b = ~w_strobe;
          w_rd_b   = ~w_strobe;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_type    <= C_MRD;
      r_m1      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wcnt    <= '0;
      r_err     <= 1'b0;
      r_r       <= '0;
      adr       <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      mreq_b    <= 1'b1;
      iorq_b    <= 1'b1;
      rd_b      <= 1'b1;
      wr_b      <= 1'b1;
      m1_b      <= 1'b1;
      rfsh_b    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_type  <= w_type;
        r_m1    <= w_m1;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (w_state_nxt == S_T1) begin
        r_wcnt <= '0;
        r_err  <= 1'b0;
      end else if (w_state_nxt == S_TW) begin
        r_wcnt <= r_wcnt + 8'd1;
      end
      if (w_tmo_hit) r_err <= 1'b1;
      adr       <= w_adr;
      data_out  <= w_dout;
      data_oe   <= w_oe;
      mreq_b    <= w_mreq_b;
      iorq_b    <= w_iorq_b;
      rd_b      <= w_rd_b;
      wr_b      <= w_wr_b;
      m1_b      <= w_m1_b;
      rfsh_b    <= w_rfsh_b;
      rsp_valid <= w_done;
      rsp_err   <= w_done & r_err;
      if (w_fetch_cap) begin
        rsp_rdata <= data_in;
      end else if (w_done && !r_m1) begin
        rsp_rdata <= ((r_type == C_MRD) || (r_type == C_IORD)) ? data_in : 8'h00;
      end
      // R[7] is left untouched; only the low seven bits count refreshes.
      if (w_done && r_m1) r_r <= {r_r[7], r_r[6:0] + 7'd1};
    end
  end

endmodule
